// File: rtl/md_pkg.sv
// Shared op encodings, FSM states and op-class helpers
// for the iterative RV32M multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic is_div(
    input logic [2:0] op
  );
    return op[2];
  endfunction

  function automatic logic is_rem(
    input logic [2:0] op
  );
    return op[2] & op[1];
  endfunction

  function automatic logic op_signed_a(
    input logic [2:0] op
  );
    return (op == MD_MULH)
        || (op == MD_MULHSU)
        || (op == MD_DIV)
        || (op == MD_REM);
  endfunction

  function automatic logic op_signed_b(
    input logic [2:0] op
  );
    return (op == MD_MULH)
        || (op == MD_DIV)
        || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_operand_prep.sv
// Operand conditioning: magnitudes, effective signs and
// the divide fast-path detectors.
module md_operand_prep
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_abs_a,
  output logic [XLEN-1:0] o_abs_b,
  output logic            o_sign_a,
  output logic            o_sign_b,
  output logic            o_div_by_zero,
  output logic            o_signed_ovf
);

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  logic w_sa;
  logic w_sb;
  logic w_div;
  logic w_a_min;
  logic w_b_m1;

  assign w_sa = op_signed_a(i_op) & i_a[XLEN-1];
  assign w_sb = op_signed_b(i_op) & i_b[XLEN-1];
  assign w_div = is_div(i_op);

  assign w_a_min = (i_a == MIN_NEG);
  assign w_b_m1  = (i_b == {XLEN{1'b1}});

  assign o_sign_a = w_sa;
  assign o_sign_b = w_sb;
  assign o_abs_a  = w_sa ? (~i_a + 1'b1) : i_a;
  assign o_abs_b  = w_sb ? (~i_b + 1'b1) : i_b;

  assign o_div_by_zero = w_div & (i_b == '0);
  // only DIV/REM are signed on both sides
  assign o_signed_ovf  = w_div
                       & op_signed_b(i_op)
                       & w_a_min
                       & w_b_m1;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide unit:
// shift-add multiply, restoring divide, 1-cycle fast path.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e r_state;
  md_state_e w_next;

  logic [2:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic [2*XLEN-1:0] r_prod;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_sa;
  logic            w_sb;
  logic            w_dbz;
  logic            w_ovf;
  logic            w_fast;
  logic            w_accept;
  logic            w_last;
  logic [XLEN-1:0] w_spec_res;

  logic [XLEN:0]     w_shl;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic              w_neg;
  logic [2*XLEN-1:0] w_prod_f;
  logic [XLEN-1:0]   w_quo_f;
  logic [XLEN-1:0]   w_rem_f;
  logic [XLEN-1:0]   w_fix_res;

  md_operand_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .i_op         (op),
    .i_a          (a),
    .i_b          (b),
    .o_abs_a      (w_abs_a),
    .o_abs_b      (w_abs_b),
    .o_sign_a     (w_sa),
    .o_sign_b     (w_sb),
    .o_div_by_zero(w_dbz),
    .o_signed_ovf (w_ovf)
  );

  assign w_fast   = w_dbz | w_ovf;
  assign w_accept = (r_state == S_IDLE)
                  & start & ~flush;
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

  // dbz and ovf are exclusive (b==0 vs b==-1)
  assign w_spec_res = is_rem(op)
                    ? (w_dbz ? a : '0)
                    : (w_dbz ? '1 : a);

  // restoring step: partial remainder needs one extra bit
  assign w_shl  = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_shl - {1'b0, r_dvsr};
  assign w_ge   = ~w_diff[XLEN];

  assign w_neg    = r_sa ^ r_sb;
  assign w_prod_f = w_neg ? (~r_prod + 1'b1) : r_prod;
  assign w_quo_f  = w_neg ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_f  = r_sa ? (~r_rem + 1'b1) : r_rem;

  always_comb begin
    w_fix_res = '0;
    unique case (1'b1)
      (r_op == MD_MUL):
        w_fix_res = w_prod_f[XLEN-1:0];
      (!is_div(r_op) && r_op != MD_MUL):
        w_fix_res = w_prod_f[2*XLEN-1:XLEN];
      (is_div(r_op) && !r_op[1]):
        w_fix_res = w_quo_f;
      (is_div(r_op) && r_op[1]):
        w_fix_res = w_rem_f;
      default:
        w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:
        if (flush)       w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      S_FIX:
        w_next = flush ? S_IDLE : S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= op;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvsr   <= w_abs_b;
            r_cnt    <= '0;
            if (w_fast) r_result <= w_spec_res;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (is_div(r_op)) begin
              r_rem <= w_ge ? w_diff[XLEN-1:0]
                            : w_shl[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], w_ge};
            end else begin
              if (r_mplier[0])
                r_prod <= r_prod + r_mcand;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
            end
          end
        end
        S_FIX: begin
          if (!flush) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_CALC)
                | (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a cycle-level
// reference model and per-cycle output compare.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic        m_valid = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  int          m_kill = 32'h7fff_ffff;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_hold = 32'd0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [63:0] ux, uy, sx, sy, p;
    longint lx, ly;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    lx = longint'(sx);
    ly = longint'(sy);
    case (o)
      MD_MUL:    begin p = ux * uy; return p[31:0];  end
      MD_MULH:   begin p = sx * sy; return p[63:32]; end
      MD_MULHSU: begin p = sx * uy; return p[63:32]; end
      MD_MULHU:  begin p = ux * uy; return p[63:32]; end
      MD_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return x;
        return 32'(lx / ly);
      end
      MD_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return 32'd0;
        return 32'(lx % ly);
      end
      MD_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic is_fast(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic sgn;
    sgn = (o == MD_DIV) || (o == MD_REM);
    return o[2] && ((y == 0) || (sgn
      && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  // compare DUT against model every cycle
  initial begin
    logic eb, ed;
    forever begin
      @(negedge clk);
      ed = m_valid && cyc == m_k + m_lat && cyc < m_kill;
      eb = m_valid && cyc >= m_k && cyc < m_k + m_lat
        && cyc < m_kill;
      if (ed) m_hold = m_res;
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("done", {31'd0, done}, {31'd0, ed});
      chk("result", result, m_hold);
    end
  end

  task automatic launch(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    @(negedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    m_k = cyc + 1;
    m_lat = is_fast(o, x, y) ? 0 : 33;
    m_res = model(o, x, y);
    m_kill = 32'h7fff_ffff;
    m_valid = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic finish_op(
    input string nm,
    input logic [31:0] lit
  );
    for (int i = 0; i < 40 && cyc < m_k + m_lat; i++)
      @(negedge clk);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk(nm, result, lit);
  endtask

  task automatic run(
    input string nm,
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] lit
  );
    launch(o, x, y);
    finish_op(nm, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    #1 rst_n = 1'b1;

    run("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulhu", MD_MULHU, '1, '1, 32'hFFFF_FFFE);
    run("mulh", MD_MULH, '1, '1, 32'h0000_0000);
    run("mulhsu", MD_MULHSU, '1, 32'd2, 32'hFFFF_FFFF);
    run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14);
    run("remu", MD_REMU, 32'd100, 32'd7, 32'd2);
    run("div_z", MD_DIV, 32'h1234_5678, 0, 32'hFFFF_FFFF);
    run("divu_z", MD_DIVU, 32'h1234_5678, 0, 32'hFFFF_FFFF);
    run("rem_z", MD_REM, 32'h1234_5678, 0, 32'h1234_5678);
    run("remu_z", MD_REMU, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    run("div_ovf", MD_DIV, 32'h8000_0000, '1, 32'h8000_0000);
    run("rem_ovf", MD_REM, 32'h8000_0000, '1, 32'h0);
    run("divu_big", MD_DIVU, 32'h8000_0000, '1, 32'h0);
    run("remu_big", MD_REMU, 32'h8000_0000, '1, 32'h8000_0000);
    run("mul_nn", MD_MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd6);
    run("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000);
    run("mulhsu_ub", MD_MULHSU, 32'd2, 32'h8000_0000, 32'd1);
    run("div_nd", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run("rem_nd", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);

    // start while busy, then start in the DONE cycle
    launch(MD_MUL, 32'h0001_0003, 32'd5);
    repeat (8) @(negedge clk);
    #1 start = 1'b1; op = MD_DIV; a = 32'd9; b = 32'd0;
    @(negedge clk); #1 start = 1'b0;
    finish_op("mul_busy_start", 32'h0005_000F);
    #1 start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd0;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("done_start_ign", {31'd0, busy | done}, 32'd0);

    // flush together with start in IDLE
    @(negedge clk); #1;
    start = 1'b1; flush = 1'b1; op = MD_REM; b = 32'd0;
    @(negedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_ign", {31'd0, busy | done}, 32'd0);

    // flush in CALC cycle 10
    launch(MD_MUL, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    #1 flush = 1'b1; m_kill = m_k + 10;
    @(negedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    chk("flush_result", result, 32'h0005_000F);

    // async reset mid-divide
    launch(MD_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0; m_valid = 1'b0; m_hold = 32'd0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run("post_rst_div", MD_DIV, 32'd1000, 32'd3, 32'd333);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
